metaballs_multi: RTL
====================

// Module: metaballs_multi
// PURPOSE
//  Parametrised successor to the fixed metaballs renderer: N independently bouncing balls, selectable solid/banded shading, pause.
//  Consumes hvsync_generator timing (hpos/vpos/display_on/vsync) and drives the shared RGB intensity of the VGA PMOD top.
//  Field per pixel = saturating sum of per-ball linear falloffs; 2-stage pipeline; ball motion updated once per frame.
// PARAMETERS
//  SCREEN_WIDTH      640   visible columns
//  SCREEN_HEIGHT     480   visible rows
//  NUM_BALLS         4     ball count, 1..8
//  COLOR_BITS        2     output intensity width
//  RADIUS            40    bounce margin from each screen edge, pixels
//  FIELD_K           4096  per-ball contribution at distance 0
//  FIELD_SHIFT       2     contribution = FIELD_K - (d2 >> FIELD_SHIFT), floored at 0
//  THRESH            2048  solid-mode on threshold
//  BAND_SHIFT        10    banded-mode: level = sum >> BAND_SHIFT
//  VSYNC_ACTIVE_HIGH 1     vsync polarity; frame update fires on assertion edge
// PORTS
//  clk         in  1           pixel clock
//  reset       in  1           synchronous, active-high
//  vsync       in  1           from hvsync_generator
//  display_on  in  1           visible-area flag
//  hpos        in  10          pixel x
//  vpos        in  10          pixel y
//  pause       in  1           1 = freeze ball motion
//  mode        in  1           0 = solid threshold, 1 = banded
//  color       out COLOR_BITS  intensity, valid 2 cycles after hpos/vpos
//  frame_cnt   out 8           frames seen since reset, wraps 255->0
// BEHAVIOUR
//  Reset (synchronous, active-high): color=0, frame_cnt=0, pipeline regs=0, vsync edge reg=deasserted, balls to init table.
//  Init table for ball i: x=(i+1)*W/(N+1), y=(i+1)*H/(N+1); |vx|=1+(i%3), |vy|=1+((i+1)%3);
//   even i: vx>0, vy<0; odd i: vx<0, vy>0. N=4: x=128,256,384,512; y=96,192,288,384; vx=+1,-2,+3,-1; vy=-2,+3,-1,+2.
//  Frame tick: one-cycle pulse on the cycle after vsync asserts (edge vs registered copy); frame_cnt+1 on every tick.
//  Motion (tick && !pause, all balls in parallel): nx=x+vx (signed 12b);
//   nx<RADIUS -> x=RADIUS, vx=-vx; nx>W-1-RADIUS -> x=W-1-RADIUS, vx=-vx; else x=nx. y likewise with H. Pause: positions/velocities hold.
//  Stage 1 (registered): per ball dx=hpos-x, dy=vpos-y (signed 11b); d2=dx*dx+dy*dy (unsigned 21b); display_on delayed.
//  Stage 2 (registered): c_i=max(FIELD_K-(d2_i>>FIELD_SHIFT),0); sum=sat16(sum c_i), max 65535;
//   mode0: color = sum>=THRESH ? all-ones : 0;  mode1: color = min(sum>>BAND_SHIFT, 2^COLOR_BITS-1);
//   display_on (delayed 2) = 0 forces color=0.
//  Latency: exactly 2 clk from hpos/vpos/display_on/mode to color; no backpressure; new pixel every clk.
//  Tick and a visible pixel cannot coincide in legal timing; if they do, stage 1 uses pre-update positions.
//  mode/pause sampled every cycle; mode change takes effect on the next pixel through the pipe.
//  Reset mid-frame: the cycle after reset deassert color=0, then rendering restarts with the init table; frame_cnt=0.
// STRUCTURE
//  metaballs_pkg: coordinate/distance/field widths, init-table function (x,y,vx,vy per index), sat helper.
//  Sub-module metaball_ball: one ball's x/y/vx/vy registers + bounce logic, index parameter selects init entry;
//   instantiated NUM_BALLS times via generate. Top holds edge detect, frame_cnt, 2-stage field pipeline.
// TESTING
//  1 reset: hold reset 3 clk -> color=0, frame_cnt=0, ball0 at (128,96), ball2 vx=+3.
//  2 solid: mode=0, display_on=1, pixel (128,96) -> color=3 exactly 2 clk later; pixel (0,479) -> color=0.
//  3 blank: display_on=0 at (128,96) -> color=0; mode=1 at (128,96) -> 4096>>10=4, clamped color=3.
//  4 tick: one vsync pulse -> ball0 at (129,94), frame_cnt=1; pause=1 plus pulse -> ball0 unchanged, frame_cnt=2.
//  5 bounce: 72 vsync pulses, pause=0 -> ball2 x=599, vx=-3; next pulse -> x=596.
//  6 reset mid-frame after 10 ticks while rendering -> color=0 next clk, ball0 back at (128,96), frame_cnt=0.

Source files
------------

// File: rtl/metaballs_pkg.sv
// Shared widths, ball state type, init-table function and saturation helper
// for the multi-ball metaballs renderer.
package metaballs_pkg;

   localparam int COORD_W = 12;
   localparam int DELTA_W = 11;
   localparam int DIST_W  = 21;
   localparam int SUM_W   = 16;
   localparam int ACC_W   = 20;

   typedef logic signed [COORD_W-1:0] coord_t;
   typedef logic signed [DELTA_W-1:0] delta_t;
   typedef logic        [DIST_W-1:0]  dist_t;
   typedef logic        [SUM_W-1:0]   field_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
      coord_t vx;
      coord_t vy;
   } ball_state_t;

   // Balls spread along the diagonal; even indices head up-right, odd down-left.
   function automatic ball_state_t ball_init(input int idx, input int num_balls,
                                             input int width, input int height);
      ball_state_t s;
      int mvx;
      int mvy;
      mvx  = 1 + (idx % 3);
      mvy  = 1 + ((idx + 1) % 3);
      s.x  = coord_t'((idx + 1) * width / (num_balls + 1));
      s.y  = coord_t'((idx + 1) * height / (num_balls + 1));
      s.vx = idx[0] ? -coord_t'(mvx) :  coord_t'(mvx);
      s.vy = idx[0] ?  coord_t'(mvy) : -coord_t'(mvy);
      return s;
   endfunction

   function automatic field_t sat16(input logic [ACC_W-1:0] v);
      return (v > ACC_W'(65535)) ? '1 : v[SUM_W-1:0];
   endfunction

endpackage

// File: rtl/metaball_ball.sv
// One bouncing ball: position/velocity registers with edge reflection,
// advanced by one velocity step whenever step is high.
module metaball_ball
   import metaballs_pkg::*;
#(
   parameter int INDEX         = 0,
   parameter int NUM_BALLS     = 4,
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int RADIUS        = 40
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   step,
   output coord_t x,
   output coord_t y
);

   localparam ball_state_t INIT = ball_init(INDEX, NUM_BALLS, SCREEN_WIDTH, SCREEN_HEIGHT);
   localparam coord_t      LO   = coord_t'(RADIUS);
   localparam coord_t      X_HI = coord_t'(SCREEN_WIDTH - 1 - RADIUS);
   localparam coord_t      Y_HI = coord_t'(SCREEN_HEIGHT - 1 - RADIUS);

   coord_t vx;
   coord_t vy;
   coord_t nx;
   coord_t ny;
   coord_t x_next;
   coord_t y_next;
   coord_t vx_next;
   coord_t vy_next;

   always_comb begin
      nx      = x + vx;
      ny      = y + vy;
      x_next  = nx;
      y_next  = ny;
      vx_next = vx;
      vy_next = vy;
      if (nx < LO) begin
         x_next  = LO;
         vx_next = -vx;
      end else if (nx > X_HI) begin
         x_next  = X_HI;
         vx_next = -vx;
      end
      if (ny < LO) begin
         y_next  = LO;
         vy_next = -vy;
      end else if (ny > Y_HI) begin
         y_next  = Y_HI;
         vy_next = -vy;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x  <= INIT.x;
         y  <= INIT.y;
         vx <= INIT.vx;
         vy <= INIT.vy;
      end else if (step) begin
         x  <= x_next;
         y  <= y_next;
         vx <= vx_next;
         vy <= vy_next;
      end
   end

endmodule

// File: rtl/metaballs_multi.sv
// N-ball metaballs renderer: per-frame ball motion on vsync edge, and a
// 2-stage distance/field pipeline producing solid or banded intensity.
module metaballs_multi
   import metaballs_pkg::*;
#(
   parameter int SCREEN_WIDTH      = 640,
   parameter int SCREEN_HEIGHT     = 480,
   parameter int NUM_BALLS         = 4,
   parameter int COLOR_BITS        = 2,
   parameter int RADIUS            = 40,
   parameter int FIELD_K           = 4096,
   parameter int FIELD_SHIFT       = 2,
   parameter int THRESH            = 2048,
   parameter int BAND_SHIFT        = 10,
   parameter int VSYNC_ACTIVE_HIGH = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vsync,
   input  logic                  display_on,
   input  logic [9:0]            hpos,
   input  logic [9:0]            vpos,
   input  logic                  pause,
   input  logic                  mode,
   output logic [COLOR_BITS-1:0] color,
   output logic [7:0]            frame_cnt
);

   localparam dist_t  K_D      = dist_t'(FIELD_K);
   localparam field_t THRESH_F = field_t'(THRESH);
   localparam field_t LEVEL_MAX = field_t'((1 << COLOR_BITS) - 1);

   logic vs_act;
   logic vs_q;
   logic tick;
   logic step;

   coord_t bx [NUM_BALLS];
   coord_t by [NUM_BALLS];

   assign vs_act = (VSYNC_ACTIVE_HIGH != 0) ? vsync : ~vsync;
   assign tick   = vs_act & ~vs_q;
   assign step   = tick & ~pause;

   always_ff @(posedge clk) begin
      if (reset) begin
         vs_q      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         vs_q <= vs_act;
         if (tick) frame_cnt <= frame_cnt + 8'd1;
      end
   end

   for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
      metaball_ball #(
         .INDEX        (i),
         .NUM_BALLS    (NUM_BALLS),
         .SCREEN_WIDTH (SCREEN_WIDTH),
         .SCREEN_HEIGHT(SCREEN_HEIGHT),
         .RADIUS       (RADIUS)
      ) u_ball (
         .clk  (clk),
         .reset(reset),
         .step (step),
         .x    (bx[i]),
         .y    (by[i])
      );
   end

   // Stage 1: squared distance to each ball centre.
   delta_t             dx [NUM_BALLS];
   delta_t             dy [NUM_BALLS];
   logic signed [20:0] dxw [NUM_BALLS];
   logic signed [20:0] dyw [NUM_BALLS];
   dist_t              d2_next [NUM_BALLS];
   dist_t              d2_q [NUM_BALLS];
   logic               on_q1;
   logic               mode_q1;

   always_comb begin
      for (int unsigned i = 0; i < NUM_BALLS; i++) begin
         dx[i]      = delta_t'($signed({2'b00, hpos}) - bx[i]);
         dy[i]      = delta_t'($signed({2'b00, vpos}) - by[i]);
         dxw[i]     = 21'(dx[i]);
         dyw[i]     = 21'(dy[i]);
         d2_next[i] = dist_t'(dxw[i] * dxw[i] + dyw[i] * dyw[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_BALLS; i++) d2_q[i] <= '0;
         on_q1   <= 1'b0;
         mode_q1 <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_BALLS; i++) d2_q[i] <= d2_next[i];
         on_q1   <= display_on;
         mode_q1 <= mode;
      end
   end

   // Stage 2: summed linear falloff, then threshold or banding.
   dist_t                sh [NUM_BALLS];
   dist_t                contrib [NUM_BALLS];
   logic [ACC_W-1:0]     acc;
   field_t               sum;
   field_t               level;
   logic [COLOR_BITS-1:0] color_next;

   always_comb begin
      acc = '0;
      for (int unsigned i = 0; i < NUM_BALLS; i++) begin
         sh[i]      = d2_q[i] >> FIELD_SHIFT;
         contrib[i] = (sh[i] >= K_D) ? '0 : K_D - sh[i];
         acc        = acc + ACC_W'(contrib[i]);
      end
      sum   = sat16(acc);
      level = sum >> BAND_SHIFT;
      if (!on_q1)
         color_next = '0;
      else if (mode_q1)
         color_next = (level >= LEVEL_MAX) ? '1 : level[COLOR_BITS-1:0];
      else
         color_next = (sum >= THRESH_F) ? '1 : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) color <= '0;
      else       color <= color_next;
   end

endmodule
